// File: rtl/stream_fifo_pkg.sv
// rtl/stream_fifo_pkg.sv - shared defaults and width helpers for stream_fifo
package stream_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AF_LEVEL   = 12;
  localparam int DEF_AE_LEVEL   = 2;

  // Bits needed to hold the values 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  function automatic int addr_w(input int depth);
    return clog2(depth);
  endfunction

  // Level must reach DEPTH+1 when the output slice is present.
  function automatic int lvl_w(input int depth);
    return clog2(depth + 2);
  endfunction

endpackage

// File: rtl/stream_fifo_out_slice.sv
// rtl/stream_fifo_out_slice.sv - one-entry valid/ready register stage on the FIFO head
module stream_fifo_out_slice
  import stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_in_ready,
  output logic                  o_out_valid,
  output logic [DATA_WIDTH-1:0] o_out_data,
  input  logic                  i_out_ready
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  assign o_in_ready  = ~r_valid | i_out_ready;
  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (o_in_ready) begin
      r_valid <= i_in_valid;
      if (i_in_valid) r_data <= i_in_data;
    end
  end

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - single-clock valid/ready FIFO with level, flags and flush
// STREAM_FIFO_OUT_REG_EN adds a registered head slice (capacity DEPTH+1, latency 2).
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  DEPTH      = DEF_DEPTH,
  parameter int  AF_LEVEL   = DEF_AF_LEVEL,
  parameter int  AE_LEVEL   = DEF_AE_LEVEL,
  localparam int ADDR_W     = addr_w(DEPTH),
  localparam int LVL_W      = lvl_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  m_valid,
  input  logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_ready,
  output logic                  s_valid,
  output logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_ready,
  output logic [LVL_W-1:0]      level,
  output logic                  almost_full,
  output logic                  almost_empty
);

`ifdef STREAM_FIFO_OUT_REG_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = DEPTH;
`endif

  localparam logic [LVL_W-1:0]  L_CAP  = LVL_W'(CAP);
  localparam logic [LVL_W-1:0]  L_AF   = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0]  L_AE   = LVL_W'(AE_LEVEL);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]      r_level, w_level_nxt, w_ram_level;
  logic                  r_almost_full, r_almost_empty;
  logic                  w_push, w_pop, w_ram_pop, w_ram_valid;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == A_LAST) ? '0 : p + 1'b1;
  endfunction

  assign m_ready      = (r_level != L_CAP);
  assign w_push       = m_valid & m_ready;
  assign w_pop        = s_valid & s_ready;
  assign level        = r_level;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;

`ifdef STREAM_FIFO_OUT_REG_EN
  logic w_slice_ready, w_slice_valid;

  // r_level counts RAM plus slice, so the RAM share is the total minus the slice bit.
  assign w_ram_level = r_level - LVL_W'(w_slice_valid);
  assign w_ram_valid = (w_ram_level != '0);
  assign w_ram_pop   = w_ram_valid & w_slice_ready;
  assign s_valid     = w_slice_valid;

  stream_fifo_out_slice #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_slice (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (flush),
    .i_in_valid  (w_ram_valid),
    .i_in_data   (r_mem[r_rd_ptr]),
    .o_in_ready  (w_slice_ready),
    .o_out_valid (w_slice_valid),
    .o_out_data  (s_data),
    .i_out_ready (s_ready)
  );
`else
  assign w_ram_level = r_level;
  assign w_ram_valid = (w_ram_level != '0);
  assign w_ram_pop   = w_pop;
  assign s_valid     = w_ram_valid;
  assign s_data      = r_mem[r_rd_ptr];
`endif

  always_comb begin
    w_level_nxt = r_level;
    if (flush)                 w_level_nxt = '0;
    else if (w_push && !w_pop) w_level_nxt = r_level + 1'b1;
    else if (!w_push && w_pop) w_level_nxt = r_level - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_level        <= w_level_nxt;
      r_almost_full  <= (w_level_nxt >= L_AF);
      r_almost_empty <= (w_level_nxt <= L_AE);
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push)    r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_ram_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= m_data;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - scoreboard bench for stream_fifo at DEPTH 5 and DEPTH 16
module tb_stream_fifo;

`ifdef STREAM_FIFO_OUT_REG_EN
  localparam int OUTREG = 1;
`else
  localparam int OUTREG = 0;
`endif
  localparam int LAT = 1 + OUTREG;
  localparam int D0 = 5,  AF0 = 4,  AE0 = 1;
  localparam int D1 = 16, AF1 = 12, AE1 = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush [2];
  logic       mv    [2];
  logic       sr    [2];
  logic [7:0] md    [2];
  logic       mr    [2];
  logic       sv    [2];
  logic       af    [2];
  logic       ae    [2];
  logic [7:0] sd    [2];
  logic [4:0] lvl   [2];
  logic [2:0] lvl0;
  logic [4:0] lvl1;

  int cap [2];
  int afl [2];
  int ael [2];
  int mlvl[2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int t0[$];
  int t1[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign lvl[0] = {2'b00, lvl0};
  assign lvl[1] = lvl1;

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(D0), .AF_LEVEL(AF0), .AE_LEVEL(AE0)) u_d5 (
    .clk(clk), .reset_n(reset_n), .flush(flush[0]),
    .m_valid(mv[0]), .m_data(md[0]), .m_ready(mr[0]),
    .s_valid(sv[0]), .s_data(sd[0]), .s_ready(sr[0]),
    .level(lvl0), .almost_full(af[0]), .almost_empty(ae[0])
  );

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(D1), .AF_LEVEL(AF1), .AE_LEVEL(AE1)) u_d16 (
    .clk(clk), .reset_n(reset_n), .flush(flush[1]),
    .m_valid(mv[1]), .m_data(md[1]), .m_ready(mr[1]),
    .s_valid(sv[1]), .s_data(sd[1]), .s_ready(sr[1]),
    .level(lvl1), .almost_full(af[1]), .almost_empty(ae[1])
  );

  task automatic chk(input int i, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[fifo%0d]: observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic clear_model(input int i);
    mlvl[i] = 0;
    if (i == 0) begin q0.delete(); t0.delete(); end
    else        begin q1.delete(); t1.delete(); end
  endtask

  // One clock: drive at negedge, predict push/pop, check registered results at next negedge.
  task automatic step(input int i, input bit v, input logic [7:0] d, input bit r);
    bit         e_push, e_pop, e_sv;
    logic [7:0] e_d;
    mv[i] = v; md[i] = d; sr[i] = r;
    e_sv = 1'b0;
    if (i == 0) begin
      if (q0.size() != 0) e_sv = (cyc >= t0[0] + LAT);
    end else begin
      if (q1.size() != 0) e_sv = (cyc >= t1[0] + LAT);
    end
    chk(i, "m_ready", {31'd0, mr[i]}, {31'd0, mlvl[i] != cap[i]});
    chk(i, "s_valid", {31'd0, sv[i]}, {31'd0, e_sv});
    e_push = v && (mlvl[i] != cap[i]);
    e_pop  = e_sv && r;
    if (e_pop) begin
      if (i == 0) begin e_d = q0.pop_front(); void'(t0.pop_front()); end
      else        begin e_d = q1.pop_front(); void'(t1.pop_front()); end
      chk(i, "s_data", {24'd0, sd[i]}, {24'd0, e_d});
    end
    if (e_push) begin
      if (i == 0) begin q0.push_back(d); t0.push_back(cyc); end
      else        begin q1.push_back(d); t1.push_back(cyc); end
    end
    @(posedge clk);
    mlvl[i] = mlvl[i] + int'(e_push) - int'(e_pop);
    @(negedge clk);
    chk(i, "level", {27'd0, lvl[i]}, mlvl[i]);
    chk(i, "almost_full", {31'd0, af[i]}, {31'd0, mlvl[i] >= afl[i]});
    chk(i, "almost_empty", {31'd0, ae[i]}, {31'd0, mlvl[i] <= ael[i]});
    mv[i] = 1'b0; sr[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int guard;
    guard = 0;
    while (qsize(i) > 0 && guard < 40) begin
      step(i, 1'b0, 8'h00, 1'b1);
      guard++;
    end
    chk(i, "drain_done", qsize(i), 0);
  endtask

  task automatic fill(input int i, input logic [7:0] base);
    int k;
    k = 0;
    while (mlvl[i] != cap[i] && k < 40) begin
      step(i, 1'b1, base + 8'(k), 1'b0);
      k++;
    end
  endtask

  task automatic do_flush(input int i);
    flush[i] = 1'b1; mv[i] = 1'b1; md[i] = 8'hEE; sr[i] = 1'b1;
    @(posedge clk);
    clear_model(i);
    @(negedge clk);
    flush[i] = 1'b0; mv[i] = 1'b0; sr[i] = 1'b0;
    chk(i, "flush_level", {27'd0, lvl[i]}, 0);
    chk(i, "flush_s_valid", {31'd0, sv[i]}, 0);
    chk(i, "flush_almost_empty", {31'd0, ae[i]}, 1);
  endtask

  initial begin
    cap[0] = D0 + OUTREG; afl[0] = AF0; ael[0] = AE0;
    cap[1] = D1 + OUTREG; afl[1] = AF1; ael[1] = AE1;
    for (int i = 0; i < 2; i++) begin
      flush[i] = 1'b0; mv[i] = 1'b1; sr[i] = 1'b0; md[i] = 8'h5A;
      clear_model(i);
    end

    // Reset held with m_valid high: nothing may be accepted.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst_m_ready", {31'd0, mr[i]}, 1);
      chk(i, "rst_s_valid", {31'd0, sv[i]}, 0);
      chk(i, "rst_level", {27'd0, lvl[i]}, 0);
      chk(i, "rst_almost_empty", {31'd0, ae[i]}, 1);
      chk(i, "rst_almost_full", {31'd0, af[i]}, 0);
      mv[i] = 1'b0;
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk(i, "post_rst_level", {27'd0, lvl[i]}, 0);

    // Non-power-of-2 fill, blocked push while full (also with a pop), wrap-around drain.
    for (int k = 0; k < 5; k++) step(0, 1'b1, 8'(k + 1), 1'b0);
    step(0, 1'b1, 8'h06, 1'b0);
    step(0, 1'b1, 8'h06, 1'b1);
    step(0, 1'b1, 8'h06, 1'b0);
    repeat (3) step(0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) step(0, 1'b1, 8'hA0 + 8'(k), 1'b0);
    drain(0);

    // Concurrent push/pop at level 3, then full with s_ready high.
    for (int k = 0; k < 3; k++) step(0, 1'b1, 8'hB0 + 8'(k), 1'b0);
    repeat (LAT) step(0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 20; k++) step(0, 1'b1, 8'hC0 + 8'(k), 1'b1);
    chk(0, "concurrent_level", {27'd0, lvl[0]}, 3);
    fill(0, 8'hD0);
    step(0, 1'b1, 8'hDF, 1'b1);
    drain(0);

    // Flags on DEPTH 16.
    for (int k = 0; k < 12; k++) step(1, 1'b1, 8'h10 + 8'(k), 1'b0);
    chk(1, "af_after_12", {31'd0, af[1]}, 1);
    for (int k = 0; k < 20 && mlvl[1] > 2; k++) step(1, 1'b0, 8'h00, 1'b1);
    chk(1, "ae_at_2", {31'd0, ae[1]}, 1);
    for (int k = 0; k < 20 && mlvl[1] < 7; k++) step(1, 1'b1, 8'h30 + 8'(k), 1'b0);

    // Flush at level 7 with push and pop requested; old data must never emerge.
    do_flush(1);
    step(1, 1'b1, 8'h55, 1'b0);
    repeat (2) step(1, 1'b0, 8'h00, 1'b0);
    drain(1);
    fill(1, 8'h60);
    chk(1, "capacity", {27'd0, lvl[1]}, D1 + OUTREG);
    step(1, 1'b1, 8'h7F, 1'b1);
    drain(1);

    // Reset in mid-stream takes effect without a clock edge.
    step(0, 1'b1, 8'h91, 1'b0);
    step(0, 1'b1, 8'h92, 1'b0);
    reset_n = 1'b0;
    #1;
    chk(0, "async_rst_level", {27'd0, lvl[0]}, 0);
    chk(0, "async_rst_s_valid", {31'd0, sv[0]}, 0);
    chk(0, "async_rst_m_ready", {31'd0, mr[0]}, 1);
    clear_model(0);
    clear_model(1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    step(0, 1'b1, 8'hAB, 1'b0);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
